issue_queue_v2: RTL
===================

# issue_queue_v2

Parametrised out-of-order issue queue; successor to the single-cycle reservation station between rename/dispatch and the execution ports. Holds renamed micro-ops until both operands are available, captures results from the common data bus (CDB), and issues the oldest ready entry per execution port. New relative to the previous generation: allocation backpressure, per-port steering with issue/ready handshakes, true age ordering via an age matrix, same-cycle CDB snoop at allocation, and full-pipeline flush.

## Interface
- RS_ENTRIES, 16, queue depth; at least 2.
- ALLOC_W, 2, allocation lanes per cycle.
- ISSUE_W, 2, execution ports.
- CDB_W, 2, CDB broadcast lanes.
- PHYS_W, 6, physical register tag width.
- ROB_W, 6, ROB tag width.
- DATA_W, 64, operand width.
- OP_W, 8, opcode width.
- PORT_W, $clog2(ISSUE_W) (minimum 1), port-select width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; invalidates every entry.
- alloc_valid  in  ALLOC_W  lane request.
- alloc_ready  out  1  high when free_count >= ALLOC_W.
- alloc_port  in  ALLOC_W×PORT_W  execution port this op is steered to.
- alloc_dst_tag, alloc_src1_tag, alloc_src2_tag  in  ALLOC_W×PHYS_W  destination and source tags.
- alloc_src1_val, alloc_src2_val  in  ALLOC_W×DATA_W  operand values.
- alloc_src1_ready, alloc_src2_ready  in  ALLOC_W  operand already valid.
- alloc_op  in  ALLOC_W×OP_W  opcode.
- alloc_rob_tag  in  ALLOC_W×ROB_W  ROB tag.
- cdb_valid  in  CDB_W  broadcast valid.
- cdb_tag  in  CDB_W×PHYS_W  broadcast tag.
- cdb_value  in  CDB_W×DATA_W  broadcast value.
- issue_valid  out  ISSUE_W  an entry is offered on this port.
- issue_ready  in  ISSUE_W  functional unit accepts.
- issue_op, issue_dst_tag, issue_src1_val, issue_src2_val, issue_rob_tag  out  per-port payload.
- free_count  out  $clog2(RS_ENTRIES+1)  number of invalid entries.

## Operation
- Entry state is registered: valid, port, tags, values, src ready bits, opcode, ROB tag. Reset clears all valid bits and the age matrix.
- Allocation:
  - Accepted only when alloc_valid[a] && alloc_ready. Dispatch must not assert alloc_valid with alloc_ready low; the bench treats this as a protocol violation and the queue ignores the request.
  - Lanes take free entries in ascending index order. Lane a takes the a-th lowest free index among accepted lanes.
- Allocation snoop: if a source is not ready and its tag matches a valid CDB lane in the same cycle, the entry stores cdb_value and sets ready. Lowest CDB index wins on a duplicate tag.
- Wakeup: every valid, not-ready source compares against all CDB lanes each cycle. On a match, the value and ready bit are written at the edge.
- Age matrix: older[i][j]=1 means entry j is older than entry i.
  - On allocation of entry i, row i = current valid mask OR the entries taken by lower-index lanes in the same cycle.
  - Column i is cleared on allocation.
- Select, per port p: the candidate set is valid && port==p && src1_ready && src2_ready. The chosen entry is the candidate with no older candidate. Combinational from registered state only.
- Issue: when issue_valid[p] && issue_ready[p], the entry is invalidated at the edge. With issue_ready low, the same entry (or an older one that became ready) is offered next cycle. Payload values must be stable while the choice is unchanged.
- Flush:
  - Clears all valid bits at the edge.
  - Overrides allocation and wakeup in the same cycle; allocations are dropped.
  - issue_valid is not masked during the flush cycle. The FU discards on flush.
- Entries freed by issue are not reusable for allocation in the same cycle. free_count reflects registered state.

## Timing
- Reset values: issue_valid=0, all payload outputs 0, free_count=RS_ENTRIES, alloc_ready=1 (when RS_ENTRIES >= ALLOC_W).
- Allocation with both sources ready: earliest issue_valid is the next cycle.
- CDB wakeup at edge N: issue_valid is possible in cycle N+1. There is no same-cycle CDB-to-issue bypass.
- Issue accept at edge N: the entry is free for allocation from cycle N+1, and free_count increments at edge N.
- Full queue: alloc_ready=0 whenever fewer than ALLOC_W entries are free, including partial availability. There is no partial acceptance.
- Reset mid-operation drops all entries asynchronously; outputs go to reset values immediately.

## Structure
- Shared core_pkg holds:
  - iq_entry_t packed struct, parameterised by the package widths PHYS_W, ROB_W, DATA_W, OP_W;
  - the default depth and width constants.
- Sub-module iq_age_matrix:
  - state: RS_ENTRIES×RS_ENTRIES;
  - inputs: alloc one-hot vectors per lane, valid mask, clear-all;
  - output: per-port oldest-of-request-mask grant, for ISSUE_W request masks.
- The top level holds the entry array, free-slot priority encoders, CDB comparators and output muxes.

## Test plan
- Reset then idle: free_count=16, alloc_ready=1, issue_valid=00.
- Allocate two ready ops, both steered to port 0, ROB tags 3 then 4, issue_ready=1: tag 3 issues in cycle 1 and tag 4 in cycle 2. free_count returns to 16.
- Allocate an op waiting on src1 tag 0x12; drive CDB tag 0x12 with value 0xDEAD in cycle 3: issue in cycle 4 with src1_val=0xDEAD.
- Allocate with src2 tag 0x05 while cdb_tag=0x05 and value 0x77 in the same cycle: entry ready, issues next cycle with src2_val=0x77.
- Fill 15 entries with unready ops: alloc_ready=0 with one free. Issue one entry and hold issue_ready=0 for 3 cycles: the same entry stays offered each cycle.
- Eight valid entries plus a simultaneous flush, alloc and CDB: next cycle free_count=16, issue_valid=00, and the allocation is not retained.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants and types for the issue queue.
// Holds the default depth/width constants and the packed entry payload type,
// which is built from the default widths.
package core_pkg;

  localparam int DEF_RS_ENTRIES = 16;
  localparam int DEF_ALLOC_W    = 2;
  localparam int DEF_ISSUE_W    = 2;
  localparam int DEF_CDB_W      = 2;
  localparam int DEF_PHYS_W     = 6;
  localparam int DEF_ROB_W      = 6;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_OP_W       = 8;
  localparam int DEF_PORT_W     = (DEF_ISSUE_W > 1) ? $clog2(DEF_ISSUE_W) : 1;

  typedef struct packed {
    logic [DEF_OP_W-1:0]   op;
    logic [DEF_PHYS_W-1:0] dst_tag;
    logic [DEF_PHYS_W-1:0] src1_tag;
    logic [DEF_PHYS_W-1:0] src2_tag;
    logic [DEF_DATA_W-1:0] src1_val;
    logic [DEF_DATA_W-1:0] src2_val;
    logic                  src1_rdy;
    logic                  src2_rdy;
    logic [DEF_ROB_W-1:0]  rob_tag;
  } iq_entry_t;

endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix for the issue queue.
// r_older[i][j] = 1 means entry j is older than entry i.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_alloc_oh   per-lane one-hot of the entry allocated this cycle (0 = none)
//   i_valid      current registered valid mask
//   i_clear      clears the whole matrix (flush)
//   i_req        per-port request masks (ready candidates)
//   o_grant      per-port one-hot oldest request (0 when no request)
module iq_age_matrix
  import core_pkg::*;
#(
  parameter int N       = DEF_RS_ENTRIES,
  parameter int ALLOC_W = DEF_ALLOC_W,
  parameter int ISSUE_W = DEF_ISSUE_W
)(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ALLOC_W-1:0][N-1:0]       i_alloc_oh,
  input  logic [N-1:0]                    i_valid,
  input  logic                            i_clear,
  input  logic [ISSUE_W-1:0][N-1:0]       i_req,
  output logic [ISSUE_W-1:0][N-1:0]       o_grant
);

  logic [N-1:0][N-1:0]       r_older;
  logic [ALLOC_W-1:0][N-1:0] w_row;
  logic [N-1:0]              w_alloc_any;

  // A lane's new row also marks entries taken by lower lanes this cycle as older.
  always_comb begin
    w_alloc_any = '0;
    w_row       = '0;
    for (int a = 0; a < ALLOC_W; a++) begin
      w_row[a]    = i_valid | w_alloc_any;
      w_alloc_any = w_alloc_any | i_alloc_oh[a];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_older <= '0;
    end else if (i_clear) begin
      r_older <= '0;
    end else begin
      // Clear columns of newly allocated entries, then overwrite their rows.
      for (int r = 0; r < N; r++)
        r_older[r] <= r_older[r] & ~w_alloc_any;
      for (int a = 0; a < ALLOC_W; a++)
        for (int i = 0; i < N; i++)
          if (i_alloc_oh[a][i]) r_older[i] <= w_row[a];
    end
  end

  always_comb begin
    o_grant = '0;
    for (int p = 0; p < ISSUE_W; p++)
      for (int i = 0; i < N; i++)
        o_grant[p][i] = i_req[p][i] & ~(|(i_req[p] & r_older[i]));
  end

endmodule

// File: rtl/issue_queue_v2.sv
// Out-of-order issue queue: holds renamed micro-ops until both sources are
// ready, captures CDB results (including at allocation), and offers the oldest
// ready entry on each execution port with a valid/ready handshake.
// Ports:
//   clk, reset_n, flush             clock, async active-low reset, sync flush
//   alloc_*                         ALLOC_W allocation lanes, alloc_ready backpressure
//   cdb_valid/tag/value             CDB_W broadcast lanes
//   issue_valid/ready + payload     ISSUE_W execution ports
//   free_count                      number of invalid entries
module issue_queue_v2
  import core_pkg::*;
#(
  parameter int RS_ENTRIES = DEF_RS_ENTRIES,
  parameter int ALLOC_W    = DEF_ALLOC_W,
  parameter int ISSUE_W    = DEF_ISSUE_W,
  parameter int CDB_W      = DEF_CDB_W,
  parameter int PHYS_W     = DEF_PHYS_W,
  parameter int ROB_W      = DEF_ROB_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int OP_W       = DEF_OP_W,
  parameter int PORT_W     = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
)(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic [ALLOC_W-1:0]               alloc_valid,
  output logic                             alloc_ready,
  input  logic [ALLOC_W-1:0][PORT_W-1:0]   alloc_port,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]   alloc_dst_tag,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]   alloc_src1_tag,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]   alloc_src2_tag,
  input  logic [ALLOC_W-1:0][DATA_W-1:0]   alloc_src1_val,
  input  logic [ALLOC_W-1:0][DATA_W-1:0]   alloc_src2_val,
  input  logic [ALLOC_W-1:0]               alloc_src1_ready,
  input  logic [ALLOC_W-1:0]               alloc_src2_ready,
  input  logic [ALLOC_W-1:0][OP_W-1:0]     alloc_op,
  input  logic [ALLOC_W-1:0][ROB_W-1:0]    alloc_rob_tag,
  input  logic [CDB_W-1:0]                 cdb_valid,
  input  logic [CDB_W-1:0][PHYS_W-1:0]     cdb_tag,
  input  logic [CDB_W-1:0][DATA_W-1:0]     cdb_value,
  output logic [ISSUE_W-1:0]               issue_valid,
  input  logic [ISSUE_W-1:0]               issue_ready,
  output logic [ISSUE_W-1:0][OP_W-1:0]     issue_op,
  output logic [ISSUE_W-1:0][PHYS_W-1:0]   issue_dst_tag,
  output logic [ISSUE_W-1:0][DATA_W-1:0]   issue_src1_val,
  output logic [ISSUE_W-1:0][DATA_W-1:0]   issue_src2_val,
  output logic [ISSUE_W-1:0][ROB_W-1:0]    issue_rob_tag,
  output logic [$clog2(RS_ENTRIES+1)-1:0]  free_count
);

  localparam int N     = RS_ENTRIES;
  localparam int CNT_W = $clog2(RS_ENTRIES+1);

  logic [N-1:0]              r_valid, r_s1_rdy, r_s2_rdy;
  logic [N-1:0][PORT_W-1:0]  r_port;
  logic [N-1:0][PHYS_W-1:0]  r_dst_tag, r_s1_tag, r_s2_tag;
  logic [N-1:0][DATA_W-1:0]  r_s1_val, r_s2_val;
  logic [N-1:0][OP_W-1:0]    r_op;
  logic [N-1:0][ROB_W-1:0]   r_rob_tag;

  logic [CNT_W-1:0]              w_free_cnt;
  logic [ALLOC_W-1:0]            w_acc;
  logic [N-1:0]                  w_rem, w_alloc_any, w_fire;
  logic [ALLOC_W-1:0][N-1:0]     w_alloc_oh;
  logic [ISSUE_W-1:0][N-1:0]     w_req, w_grant;
  logic [N-1:0]                  w_wk1_hit, w_wk2_hit;
  logic [N-1:0][DATA_W-1:0]      w_wk1_val, w_wk2_val;
  logic [ALLOC_W-1:0]            w_sn1_hit, w_sn2_hit;
  logic [ALLOC_W-1:0][DATA_W-1:0] w_sn1_val, w_sn2_val;

  // Lowest CDB lane wins on duplicate tags: scan from the top down.
  function automatic void cdb_lookup(input logic [PHYS_W-1:0] tag,
                                     output logic hit, output logic [DATA_W-1:0] val);
    hit = 1'b0;
    val = '0;
    for (int c = CDB_W-1; c >= 0; c--)
      if (cdb_valid[c] && (cdb_tag[c] == tag)) begin
        hit = 1'b1;
        val = cdb_value[c];
      end
  endfunction

  always_comb begin
    w_free_cnt = '0;
    for (int i = 0; i < N; i++)
      if (!r_valid[i]) w_free_cnt = w_free_cnt + CNT_W'(1);
  end

  assign free_count  = w_free_cnt;
  assign alloc_ready = (w_free_cnt >= CNT_W'(ALLOC_W));
  assign w_acc       = alloc_valid & {ALLOC_W{alloc_ready & ~flush}};

  // Free-slot priority encoders: each accepted lane peels off the lowest free bit.
  always_comb begin
    w_rem       = ~r_valid;
    w_alloc_oh  = '0;
    w_alloc_any = '0;
    for (int a = 0; a < ALLOC_W; a++)
      if (w_acc[a]) begin
        w_alloc_oh[a] = w_rem & (~w_rem + N'(1));
        w_rem         = w_rem & ~w_alloc_oh[a];
        w_alloc_any   = w_alloc_any | w_alloc_oh[a];
      end
  end

  always_comb begin
    w_wk1_hit = '0; w_wk2_hit = '0; w_wk1_val = '0; w_wk2_val = '0;
    w_sn1_hit = '0; w_sn2_hit = '0; w_sn1_val = '0; w_sn2_val = '0;
    for (int i = 0; i < N; i++) begin
      cdb_lookup(r_s1_tag[i], w_wk1_hit[i], w_wk1_val[i]);
      cdb_lookup(r_s2_tag[i], w_wk2_hit[i], w_wk2_val[i]);
    end
    for (int a = 0; a < ALLOC_W; a++) begin
      cdb_lookup(alloc_src1_tag[a], w_sn1_hit[a], w_sn1_val[a]);
      cdb_lookup(alloc_src2_tag[a], w_sn2_hit[a], w_sn2_val[a]);
    end
  end

  always_comb begin
    w_req = '0;
    for (int p = 0; p < ISSUE_W; p++)
      for (int i = 0; i < N; i++)
        w_req[p][i] = r_valid[i] && (r_port[i] == PORT_W'(p)) && r_s1_rdy[i] && r_s2_rdy[i];
  end

  iq_age_matrix #(.N(N), .ALLOC_W(ALLOC_W), .ISSUE_W(ISSUE_W)) u_age (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_alloc_oh (w_alloc_oh),
    .i_valid    (r_valid),
    .i_clear    (flush),
    .i_req      (w_req),
    .o_grant    (w_grant)
  );

  // Output mux: grant is one-hot or zero, so an AND-OR mux yields 0 when idle.
  always_comb begin
    issue_valid = '0; issue_op = '0; issue_dst_tag = '0;
    issue_src1_val = '0; issue_src2_val = '0; issue_rob_tag = '0;
    w_fire = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      issue_valid[p] = |w_grant[p];
      if (issue_valid[p] && issue_ready[p]) w_fire = w_fire | w_grant[p];
      for (int i = 0; i < N; i++)
        if (w_grant[p][i]) begin
          issue_op[p]       = issue_op[p]       | r_op[i];
          issue_dst_tag[p]  = issue_dst_tag[p]  | r_dst_tag[i];
          issue_src1_val[p] = issue_src1_val[p] | r_s1_val[i];
          issue_src2_val[p] = issue_src2_val[p] | r_s2_val[i];
          issue_rob_tag[p]  = issue_rob_tag[p]  | r_rob_tag[i];
        end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0; r_s1_rdy <= '0; r_s2_rdy <= '0; r_port <= '0;
      r_dst_tag <= '0; r_s1_tag <= '0; r_s2_tag <= '0;
      r_s1_val <= '0; r_s2_val <= '0; r_op <= '0; r_rob_tag <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      // Issued slots are freed here but cannot be re-taken this cycle,
      // since the free encoders only see the registered valid mask.
      r_valid <= (r_valid & ~w_fire) | w_alloc_any;
      for (int i = 0; i < N; i++) begin
        if (r_valid[i] && !r_s1_rdy[i] && w_wk1_hit[i]) begin
          r_s1_rdy[i] <= 1'b1;
          r_s1_val[i] <= w_wk1_val[i];
        end
        if (r_valid[i] && !r_s2_rdy[i] && w_wk2_hit[i]) begin
          r_s2_rdy[i] <= 1'b1;
          r_s2_val[i] <= w_wk2_val[i];
        end
      end
      for (int a = 0; a < ALLOC_W; a++)
        for (int i = 0; i < N; i++)
          if (w_alloc_oh[a][i]) begin
            r_port[i]    <= alloc_port[a];
            r_dst_tag[i] <= alloc_dst_tag[a];
            r_s1_tag[i]  <= alloc_src1_tag[a];
            r_s2_tag[i]  <= alloc_src2_tag[a];
            r_op[i]      <= alloc_op[a];
            r_rob_tag[i] <= alloc_rob_tag[a];
            r_s1_rdy[i]  <= alloc_src1_ready[a] | w_sn1_hit[a];
            r_s2_rdy[i]  <= alloc_src2_ready[a] | w_sn2_hit[a];
            r_s1_val[i]  <= (!alloc_src1_ready[a] && w_sn1_hit[a]) ? w_sn1_val[a] : alloc_src1_val[a];
            r_s2_val[i]  <= (!alloc_src2_ready[a] && w_sn2_hit[a]) ? w_sn2_val[a] : alloc_src2_val[a];
          end
    end
  end

endmodule
